// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: screen geometry defaults, RGB111 colours,
// drawing opcodes and the painter state encoding.
package fb_pkg;

   localparam int unsigned FB_SCREEN_X = 128;
   localparam int unsigned FB_SCREEN_Y = 96;
   localparam int unsigned FB_AW       = 14;
   localparam int unsigned FB_DW       = 3;

   // Widened raster coordinate widths so x+w and y+h never wrap
   localparam int unsigned XW = 9;
   localparam int unsigned YW = 8;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b001;
   localparam logic [2:0] WHITE = 3'b111;

   localparam logic OP_FILL  = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_raster_cnt.sv
// Raster walker: x/y position and RAM address, built from a row base plus
// column increments. SCREEN_X is a power of two so the start row base is a shift.
module fb_raster_cnt
   import fb_pkg::*;
#(
   parameter int unsigned SCREEN_X = FB_SCREEN_X,
   parameter int unsigned AW       = FB_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [XW-1:0] start_x,
   input  logic [XW-1:0] end_x,
   input  logic [YW-1:0] start_y,
   input  logic [YW-1:0] end_y,
   output logic [AW-1:0] addr,
   output logic          last
);

   localparam int unsigned XSH = $clog2(SCREEN_X);

   logic [XW-1:0] cur_x;
   logic [XW-1:0] x0;
   logic [XW-1:0] x_end;
   logic [YW-1:0] cur_y;
   logic [YW-1:0] y_end;
   logic [AW-1:0] row_base;
   logic          row_end;

   assign row_end = (cur_x + XW'(1)) == x_end;
   assign last    = row_end && ((cur_y + YW'(1)) == y_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_x    <= '0;
         x0       <= '0;
         x_end    <= '0;
         cur_y    <= '0;
         y_end    <= '0;
         row_base <= '0;
         addr     <= '0;
      end else if (load) begin
         cur_x    <= start_x;
         x0       <= start_x;
         x_end    <= end_x;
         cur_y    <= start_y;
         y_end    <= end_y;
         row_base <= AW'(start_y) << XSH;
         addr     <= (AW'(start_y) << XSH) + AW'(start_x);
      end else if (step) begin
         if (row_end) begin
            // wrap to the left edge of the next row
            cur_x    <= x0;
            cur_y    <= cur_y + YW'(1);
            row_base <= row_base + AW'(SCREEN_X);
            addr     <= row_base + AW'(SCREEN_X) + AW'(x0);
         end else begin
            cur_x <= cur_x + XW'(1);
            addr  <= addr + AW'(1);
         end
      end
   end

endmodule

// File: rtl/fb_rect_painter.sv
// Rectangle fill / screen clear engine driving the frame-buffer RAM write port.
// Define RECT_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module fb_rect_painter
   import fb_pkg::*;
#(
   parameter int unsigned SCREEN_X = FB_SCREEN_X,
   parameter int unsigned SCREEN_Y = FB_SCREEN_Y,
   parameter int unsigned AW       = FB_AW,
   parameter int unsigned DW       = FB_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [7:0]    cmd_x,
   input  logic [6:0]    cmd_y,
   input  logic [7:0]    cmd_w,
   input  logic [6:0]    cmd_h,
   input  logic [DW-1:0] cmd_color,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr,
   output logic          busy,
   output logic          done,
   output logic          cmd_err
);

   fb_state_e     state;
   fb_state_e     state_nxt;
   logic          accept;
   logic          last;
   logic          empty;
   logic          oob;
   logic [XW-1:0] sum_x;
   logic [YW-1:0] sum_y;
   logic [XW-1:0] ld_x;
   logic [XW-1:0] ld_end_x;
   logic [YW-1:0] ld_y;
   logic [YW-1:0] ld_end_y;
   logic [DW-1:0] color_q;

   assign accept = cmd_valid && (state == ST_IDLE);

   // Command decode: start/end corners plus empty and out-of-bounds flags
   always_comb begin
      sum_x    = {1'b0, cmd_x} + {1'b0, cmd_w};
      sum_y    = {1'b0, cmd_y} + {1'b0, cmd_h};
      ld_x     = '0;
      ld_y     = '0;
      ld_end_x = XW'(SCREEN_X);
      ld_end_y = YW'(SCREEN_Y);
      empty    = 1'b0;
      oob      = 1'b0;
      if (cmd_op == OP_FILL) begin
         ld_x = {1'b0, cmd_x};
         ld_y = {1'b0, cmd_y};
`ifdef RECT_CLIP_EN
         ld_end_x = (sum_x > XW'(SCREEN_X)) ? XW'(SCREEN_X) : sum_x;
         ld_end_y = (sum_y > YW'(SCREEN_Y)) ? YW'(SCREEN_Y) : sum_y;
         empty    = (cmd_w == 8'd0) || (cmd_h == 7'd0) ||
                    (ld_x >= XW'(SCREEN_X)) || (ld_y >= YW'(SCREEN_Y));
`else
         ld_end_x = sum_x;
         ld_end_y = sum_y;
         empty    = (cmd_w == 8'd0) || (cmd_h == 7'd0);
         oob      = (sum_x > XW'(SCREEN_X)) || (sum_y > YW'(SCREEN_Y));
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && !oob) state_nxt = empty ? ST_DONE : ST_FILL;
         end
         ST_FILL: begin
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      px_wr     = (state == ST_FILL);
      done      = (state == ST_DONE);
   end

   // Colour is held for the whole command
   always_ff @(posedge clk) begin
      if (rst)         color_q <= '0;
      else if (accept) color_q <= cmd_color;
   end

`ifdef RECT_CLIP_EN
   assign cmd_err = 1'b0;
`else
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= accept && oob;
   end

   assign cmd_err = err_q;
`endif

   assign mem_px_data = color_q;

   fb_raster_cnt #(
      .SCREEN_X (SCREEN_X),
      .AW       (AW)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (state == ST_FILL),
      .start_x (ld_x),
      .end_x   (ld_end_x),
      .start_y (ld_y),
      .end_y   (ld_end_y),
      .addr    (mem_px_addr),
      .last    (last)
   );

endmodule

// File: tb/tb_fb_rect_painter.sv
// Scoreboard bench for fb_rect_painter: stimulus posts cycle-stamped expected
// write/done/error events and signal probes; the monitor pops and compares.
module tb_fb_rect_painter;
   import fb_pkg::*;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 3;
   localparam int K_WR = 0, K_DONE = 1, K_ERR = 2, K_NEVER = 9;
   localparam int P_READY = 0, P_WR = 1, P_BUSY = 2, P_DONE = 3,
                  P_ERR = 4, P_ADDR = 5, P_DATA = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_op = 1'b0;
   logic [7:0]    cmd_x = '0;
   logic [6:0]    cmd_y = '0;
   logic [7:0]    cmd_w = '0;
   logic [6:0]    cmd_h = '0;
   logic [DW-1:0] cmd_color = '0;
   logic          cmd_ready;
   logic [AW-1:0] mem_px_addr;
   logic [DW-1:0] mem_px_data;
   logic          px_wr;
   logic          busy;
   logic          done;
   logic          cmd_err;

   fb_rect_painter dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_w       (cmd_w),
      .cmd_h       (cmd_h),
      .cmd_color   (cmd_color),
      .mem_px_addr (mem_px_addr),
      .mem_px_data (mem_px_data),
      .px_wr       (px_wr),
      .busy        (busy),
      .done        (done),
      .cmd_err     (cmd_err)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int kind; int cyc; int addr; int data;} ev_t;
   typedef struct {int cyc; int id; int val;} pr_t;

   ev_t evq[$];
   pr_t prq[$];
   int  checks = 0;
   int  failures = 0;
   bit  end_req = 1'b0;

   // ---------------- stimulus-side helpers (queue producers) ----------------
   task automatic push_ev(input int kind, input int c, input int a, input int d);
      ev_t e;
      e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
      evq.push_back(e);
   endtask

   task automatic probe(input int c, input int id, input int v);
      pr_t p;
      int  i = 0;
      p.cyc = c; p.id = id; p.val = v;
      while (i < prq.size() && prq[i].cyc <= c) i++;
      prq.insert(i, p);
   endtask

   task automatic send(input logic op, input logic [7:0] x, input logic [6:0] y,
                       input logic [7:0] w, input logic [6:0] h,
                       input logic [DW-1:0] col, output int acc);
      @(posedge clk); #1;
      cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = col;
      cmd_valid = 1'b1;
      acc = -1;
      for (int n = 0; n < 20000 && acc < 0; n++) begin
         @(negedge clk);
         if (cmd_ready) acc = cyc + 1;
      end
      if (acc >= 0) begin
         @(posedge clk); #1;
      end else begin
         push_ev(K_NEVER, -1, 0, 0);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_quiet(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (evq.size() == 0 && prq.size() == 0) break;
         @(posedge clk);
      end
   endtask

   // ---------------- monitor / checker ----------------
   function automatic void chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d at cyc %0d", name, got, want, cyc);
      end
   endfunction

   function automatic int sig_val(input int id);
      case (id)
         P_READY: return int'(cmd_ready);
         P_WR:    return int'(px_wr);
         P_BUSY:  return int'(busy);
         P_DONE:  return int'(done);
         P_ERR:   return int'(cmd_err);
         P_ADDR:  return int'(mem_px_addr);
         default: return int'(mem_px_data);
      endcase
   endfunction

   function automatic void ev_check(input int kind, input string name);
      ev_t e;
      if (evq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_%s got=1 want=0 at cyc %0d addr=%0d", name, cyc, mem_px_addr);
      end else begin
         e = evq.pop_front();
         chk({name, "_kind"}, kind, e.kind);
         chk({name, "_cycle"}, cyc, e.cyc);
         if (kind == K_WR && e.kind == K_WR) begin
            chk("wr_addr", int'(mem_px_addr), e.addr);
            chk("wr_data", int'(mem_px_data), e.data);
            chk("wr_busy", int'(busy), 1);
         end
      end
   endfunction

   always @(negedge clk) begin
      while (prq.size() > 0 && prq[0].cyc <= cyc) begin
         pr_t p;
         p = prq.pop_front();
         if (p.cyc == cyc) chk($sformatf("probe_%0d", p.id), sig_val(p.id), p.val);
         else              chk("probe_late", cyc, p.cyc);
      end
      if (px_wr)   ev_check(K_WR, "write");
      if (done)    ev_check(K_DONE, "done");
      if (cmd_err) ev_check(K_ERR, "cmd_err");
      if (end_req) begin
         chk("events_left", evq.size(), 0);
         chk("probes_left", prq.size(), 0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #(40 * 60000);
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int acc, acc_a, acc_b;

      // reset values, sampled while rst is still asserted
      probe(2, P_READY, 1); probe(2, P_WR, 0);   probe(2, P_BUSY, 0);
      probe(2, P_DONE, 0);  probe(2, P_ERR, 0);  probe(2, P_ADDR, 0);
      probe(2, P_DATA, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 1: fill x=2 y=3 w=3 h=2 red
      send(OP_FILL, 8'd2, 7'd3, 8'd3, 7'd2, RED, acc);
      push_ev(K_WR, acc + 0, 386, 4); push_ev(K_WR, acc + 1, 387, 4);
      push_ev(K_WR, acc + 2, 388, 4); push_ev(K_WR, acc + 3, 514, 4);
      push_ev(K_WR, acc + 4, 515, 4); push_ev(K_WR, acc + 5, 516, 4);
      push_ev(K_DONE, acc + 6, 0, 0);
      probe(acc + 1, P_READY, 0); probe(acc + 1, P_BUSY, 1);
      probe(acc + 7, P_READY, 1); probe(acc + 7, P_WR, 0);
      wait_quiet(200);

      // 2: clear to black
      send(OP_CLEAR, 8'd50, 7'd50, 8'd1, 7'd1, BLACK, acc);
      for (int i = 0; i < 12288; i++) push_ev(K_WR, acc + i, i, 0);
      push_ev(K_DONE, acc + 12288, 0, 0);
      probe(acc + 12289, P_READY, 1); probe(acc + 12289, P_WR, 0);
      wait_quiet(13000);

      // 3: empty rectangle
      send(OP_FILL, 8'd5, 7'd5, 8'd0, 7'd3, WHITE, acc);
      push_ev(K_DONE, acc, 0, 0);
      probe(acc, P_WR, 0); probe(acc + 1, P_READY, 1);
      wait_quiet(100);

      // 4: second command held while the first is drawing; fields change after accept
      send(OP_FILL, 8'd10, 7'd0, 8'd4, 7'd1, GREEN, acc_a);
      for (int i = 0; i < 4; i++) push_ev(K_WR, acc_a + i, 10 + i, 2);
      push_ev(K_DONE, acc_a + 4, 0, 0);
      probe(acc_a + 5, P_READY, 1);
      send(OP_FILL, 8'd0, 7'd1, 8'd2, 7'd2, RED, acc_b);
      cmd_x = 8'd99; cmd_y = 7'd50; cmd_w = 8'd9; cmd_h = 7'd9; cmd_color = BLUE;
      push_ev(K_WR, acc_a + 6, 128, 4); push_ev(K_WR, acc_a + 7, 129, 4);
      push_ev(K_WR, acc_a + 8, 256, 4); push_ev(K_WR, acc_a + 9, 257, 4);
      push_ev(K_DONE, acc_a + 10, 0, 0);
      wait_quiet(200);

      // right-edge single pixel fits exactly
      send(OP_FILL, 8'd127, 7'd0, 8'd1, 7'd1, WHITE, acc);
      push_ev(K_WR, acc, 127, 7); push_ev(K_DONE, acc + 1, 0, 0);
      wait_quiet(100);

      // 5: bottom-right overhang, then a fully off-screen rectangle
      send(OP_FILL, 8'd126, 7'd95, 8'd4, 7'd4, GREEN, acc);
`ifdef RECT_CLIP_EN
      push_ev(K_WR, acc, 12286, 2); push_ev(K_WR, acc + 1, 12287, 2);
      push_ev(K_DONE, acc + 2, 0, 0);
      probe(acc + 3, P_READY, 1);
`else
      push_ev(K_ERR, acc, 0, 0);
      probe(acc, P_READY, 1); probe(acc, P_WR, 0); probe(acc + 1, P_ERR, 0);
`endif
      wait_quiet(100);
      send(OP_FILL, 8'd200, 7'd0, 8'd1, 7'd1, RED, acc);
`ifdef RECT_CLIP_EN
      push_ev(K_DONE, acc, 0, 0);
`else
      push_ev(K_ERR, acc, 0, 0);
`endif
      probe(acc + 1, P_READY, 1);
      wait_quiet(100);

      // 6: reset five writes into a clear
      send(OP_CLEAR, 8'd0, 7'd0, 8'd0, 7'd0, WHITE, acc);
      for (int i = 0; i < 5; i++) push_ev(K_WR, acc + i, i, 7);
      probe(acc + 5, P_WR, 0); probe(acc + 5, P_READY, 1); probe(acc + 5, P_BUSY, 0);
      probe(acc + 30, P_WR, 0); probe(acc + 30, P_DONE, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      wait_quiet(100);
      repeat (10) @(posedge clk);

      // engine still usable after the aborted clear
      send(OP_FILL, 8'd0, 7'd0, 8'd2, 7'd2, BLUE, acc);
      push_ev(K_WR, acc, 0, 1);     push_ev(K_WR, acc + 1, 1, 1);
      push_ev(K_WR, acc + 2, 128, 1); push_ev(K_WR, acc + 3, 129, 1);
      push_ev(K_DONE, acc + 4, 0, 0);
      wait_quiet(100);
      repeat (3) @(posedge clk);

      end_req = 1'b1;
   end

endmodule
